alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the datapath's combinational AND/ADD unit.
- Adds an 8-operation set, status flags, and a multi-cycle shift-add multiplier.
- Uses valid/ready on both sides and sits between the control unit's operand-issue stage and the register writeback stage.
- Single-cycle ops sustain one result per clock; MUL stalls the issue side while it iterates.

Parameters:
- WIDTH, 16: operand/result width in bits; must be ≥4.
- SHW, $clog2(WIDTH): shift-amount width, derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  unit can accept an op this cycle.
- op  input  3  opcode (encodings in alu_pkg).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; low SHW bits are the shift amount for shifts.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  registered result.
- flag_z  output  1  result == 0.
- flag_n  output  1  result[WIDTH-1].
- flag_c  output  1  carry or multiply-high-nonzero.
- flag_v  output  1  signed overflow.

Behaviour:
- Reset (async assert, synchronous release via rst_n deassert): state=IDLE, out_valid=0, result=0, all flags=0, multiplier counter=0. in_ready reads 1 once out of reset.
- Opcodes: 0 AND, 1 ADD, 2 SUB, 3 OR, 4 XOR, 5 SHL (logical), 6 SHR (logical), 7 MUL (low WIDTH bits of a*b, unsigned).
- Accept: an op is accepted on a rising edge where in_valid & in_ready.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Result consumed on an edge where out_valid & out_ready.
- States:
  - IDLE: wait for accept. Non-MUL op goes to DONE; MUL loads the multiplier and goes to BUSY.
  - BUSY: one shift-add iteration per cycle for WIDTH cycles. On the final iteration, goes to DONE with result registered.
  - DONE: out_valid=1.
    - Consume without simultaneous accept: go to IDLE.
    - Consume with simultaneous non-MUL accept: stay in DONE with the new result.
    - Consume with simultaneous MUL accept: go to BUSY, out_valid=0 next cycle.
- Latency, accept edge to out_valid high:
  - Non-MUL: 1 cycle.
  - MUL: WIDTH+1 cycles (17 for WIDTH=16).
- Throughput: back-to-back non-MUL ops with out_ready held high give one result per cycle.
- Backpressure: while out_valid=1 and out_ready=0, result and flags hold stable and in_ready=0. in_valid must be ignored, with no state change.
- Arithmetic and flag rules:
  - ADD: C = carry out of bit WIDTH-1; V = (a_msb==b_msb) & (res_msb!=a_msb).
  - SUB: computed as a + ~b + 1; C = 1 when a >= b unsigned (no borrow); V = (a_msb!=b_msb) & (res_msb!=a_msb).
  - SHL/SHR: shift by b[SHW-1:0]; amount 0 passes a through. C = last bit shifted out (0 if amount 0); V = 0.
  - AND/OR/XOR: C = V = 0.
  - MUL: C = 1 if the upper WIDTH bits of the full 2*WIDTH product are nonzero; V = 0.
  - All ops: Z and N are computed from the registered result.
- Boundary conditions:
  - Opcodes and operands are sampled only on the accept edge. Changing op, a or b during BUSY has no effect.
  - rst_n asserted mid-MUL aborts immediately; all outputs return to their reset values and no result is produced.
  - out_ready high while out_valid=0 is ignored.

Decomposition:
- Package alu_pkg holds:
  - Opcode localparams OP_AND..OP_MUL (3-bit).
  - State encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - A flag-bundle struct/typedef, if the SV flow is used.
- One sub-module: alu_mul_seq, the WIDTH-cycle shift-add unsigned multiplier.
  - Interface: start, a, b, done, prod_lo, prod_hi_nz.
  - Same clk/rst_n.
- All other ops are combinational inside alu_seq, feeding the result/flag registers.

Test Plan (WIDTH=16):
- ADD a=0x7FFF, b=0x0001, out_ready=1 -> one cycle after accept: result=0x8000, N=1, V=1, C=0, Z=0.
- SUB a=0x0005, b=0x0005 -> result=0x0000, Z=1, C=1, V=0. Then SUB a=0x0003, b=0x0005 -> result=0xFFFE, C=0, N=1.
- MUL a=0x0100, b=0x0100 -> in_ready=0 during BUSY; out_valid rises exactly 17 cycles after accept; result=0x0000, Z=1, C=1. MUL a=0x00FF, b=0x0003 -> result=0x02FD, C=0.
- Backpressure: AND a=0xF0F0, b=0xFF00 with out_ready=0 for 5 cycles -> result=0xF000 held stable, in_ready=0, an in_valid pulse during the stall is ignored. Raise out_ready -> consumed; the next op is accepted the same edge.
- Streaming: 8 consecutive XOR/OR/SHL ops with in_valid=out_ready=1 -> 8 results on 8 consecutive cycles. SHL a=0x8001, b=1 -> result=0x0002, C=1.
- Reset mid-MUL: drop rst_n 5 cycles into BUSY -> out_valid=0, result=0, flags=0 immediately (asynchronous). After release, in_ready=1 and a new ADD 2+3 returns 0x0005.

Source files
------------

// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_pkg : opcodes, FSM state encoding and flag bundle for alu_seq        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

`default_nettype wire

// File: rtl/alu_seq_if.sv
// +--------------------------------------------------------------------------+
// | alu_seq_if : operand-issue / result valid-ready bundle for alu_seq       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
  );
endinterface

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// +--------------------------------------------------------------------------+
// | alu_mul_seq : WIDTH-iteration shift-add unsigned multiplier              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_hi_nz
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  // Product is taken from the next-state accumulator so the owner can
  // register it on the same edge as the last iteration.
  assign done       = (cnt_q == CW'(1));
  assign prod_lo    = acc_d[WIDTH-1:0];
  assign prod_hi_nz = |acc_d[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// +--------------------------------------------------------------------------+
// | alu_seq : handshaked 8-op ALU with flags and sequential multiplier       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;

  logic             in_ready, accept, mul_start, mul_done, mul_hi_nz;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   sum_ext, diff_ext, shl_ext, shr_ext;
  logic [SHW-1:0]   sh_amt;
  logic             a_msb, b_msb;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign mul_start = accept && (bus.op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (mul_start),
    .a          (bus.a),
    .b          (bus.b),
    .done       (mul_done),
    .prod_lo    (mul_lo),
    .prod_hi_nz (mul_hi_nz)
  );

  // Shifts carry one extra bit so the last bit shifted out lands in it.
  always_comb begin
    a_msb    = bus.a[WIDTH-1];
    b_msb    = bus.b[WIDTH-1];
    sh_amt   = bus.b[SHW-1:0];
    sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
    diff_ext = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    shl_ext  = {1'b0, bus.a} << sh_amt;
    shr_ext  = {bus.a, 1'b0} >> sh_amt;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (bus.op)
      OP_AND: alu_res = bus.a & bus.b;
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a_msb == b_msb) && (sum_ext[WIDTH-1] != a_msb);
      end
      OP_SUB: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];
        alu_v   = (a_msb != b_msb) && (diff_ext[WIDTH-1] != a_msb);
      end
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (bus.op == OP_MUL) begin
            state_d = BUSY;
          end else begin
            state_d   = DONE;
            result_d  = alu_res;
            flags_d.z = (alu_res == '0);
            flags_d.n = alu_res[WIDTH-1];
            flags_d.c = alu_c;
            flags_d.v = alu_v;
          end
        end else if ((state_q == DONE) && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mul_done) begin
          state_d   = DONE;
          result_d  = mul_lo;
          flags_d.z = (mul_lo == '0);
          flags_d.n = mul_lo[WIDTH-1];
          flags_d.c = mul_hi_nz;
          flags_d.v = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.flag_z    = flags_q.z;
  assign bus.flag_n    = flags_q.n;
  assign bus.flag_c    = flags_q.c;
  assign bus.flag_v    = flags_q.v;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// +--------------------------------------------------------------------------+
// | tb_alu_seq : scoreboard bench for alu_seq (WIDTH=16)                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   n_out = 0;
  exp_t exp_q[$];

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [31:0] w;
    int          s, sh;
    e  = '0;
    sh = int'(b[3:0]);
    case (op)
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_XOR: e.res = a ^ b;
      OP_ADD: begin
        w = 32'(a) + 32'(b);
        e.res = w[15:0];
        e.c = w[16];
        s = int'($signed(a)) + int'($signed(b));
        e.v = (s > 32767) || (s < -32768);
      end
      OP_SUB: begin
        e.res = a - b;
        e.c = (a >= b);
        s = int'($signed(a)) - int'($signed(b));
        e.v = (s > 32767) || (s < -32768);
      end
      OP_SHL: begin
        e.res = a << sh;
        e.c = (sh != 0) ? a[16-sh] : 1'b0;
      end
      OP_SHR: begin
        e.res = a >> sh;
        e.c = (sh != 0) ? a[sh-1] : 1'b0;
      end
      default: begin
        w = 32'(a) * 32'(b);
        e.res = w[15:0];
        e.c = (w[31:16] != 16'h0000);
      end
    endcase
    e.z = (e.res == 16'h0000);
    e.n = e.res[15];
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.res = bus.result;
    o.z = bus.flag_z;
    o.n = bus.flag_n;
    o.c = bus.flag_c;
    o.v = bus.flag_v;
    return o;
  endfunction

  task automatic run_monitor();
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        got = observed();
        n_out++;
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected got=%h required=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) $display("FAIL sb_result got=%h required=%h", got, e);
          else pass_cnt++;
        end
      end
    end
  endtask

  // Starts at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, output int waited);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    waited = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    total_cnt++;
    $display("FAIL issue_timeout got=in_ready_low required=accept");
  endtask

  task automatic wait_valid(output int lat, output logic ir_seen);
    lat = 1;
    ir_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) return;
      if (bus.in_ready) ir_seen = 1'b1;
      lat++;
    end
    total_cnt++;
    $display("FAIL out_valid_timeout got=0 required=1");
  endtask

  task automatic test_reset();
    logic bad;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = OP_AND;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b required=0", bus.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.result !== 16'h0000) $display("FAIL rst_result got=%h required=0000", bus.result);
    else pass_cnt++;
    total_cnt++;
    if ({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== 4'b0000)
      $display("FAIL rst_flags got=%b required=0000", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v});
    else pass_cnt++;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b required=1", bus.in_ready);
    else pass_cnt++;
    // out_ready without a pending result must not produce anything
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad = 1'b1;
    end
    total_cnt++;
    if (bad) $display("FAIL idle_out_ready got=valid required=no_valid");
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_sub();
    int   w, lat;
    logic irs;
    bus.out_ready = 1'b1;
    issue(OP_ADD, 16'h7FFF, 16'h0001, w);
    wait_valid(lat, irs);
    total_cnt++;
    if (lat != 1) $display("FAIL add_latency got=%0d required=1", lat);
    else pass_cnt++;
    total_cnt++;
    if ({bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== {16'h8000, 4'b0101})
      $display("FAIL add_ovf got=%h required=%h", observed(), {16'h8000, 4'b0101});
    else pass_cnt++;
    @(posedge clk);
    #1;
    issue(OP_SUB, 16'h0005, 16'h0005, w);
    wait_valid(lat, irs);
    total_cnt++;
    if ({bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== {16'h0000, 4'b1010})
      $display("FAIL sub_equal got=%h required=%h", observed(), {16'h0000, 4'b1010});
    else pass_cnt++;
    @(posedge clk);
    #1;
    issue(OP_SUB, 16'h0003, 16'h0005, w);
    wait_valid(lat, irs);
    total_cnt++;
    if ({bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== {16'hFFFE, 4'b0100})
      $display("FAIL sub_borrow got=%h required=%h", observed(), {16'hFFFE, 4'b0100});
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul();
    int   w, lat;
    logic irs;
    bus.out_ready = 1'b1;
    issue(OP_MUL, 16'h0100, 16'h0100, w);
    // operands change while iterating; must not matter
    bus.op = OP_ADD;
    bus.a = 16'hFFFF;
    bus.b = 16'h1234;
    wait_valid(lat, irs);
    total_cnt++;
    if (lat != 17) $display("FAIL mul_latency got=%0d required=17", lat);
    else pass_cnt++;
    total_cnt++;
    if (irs !== 1'b0) $display("FAIL mul_busy_in_ready got=%b required=0", irs);
    else pass_cnt++;
    total_cnt++;
    if ({bus.result, bus.flag_z, bus.flag_c} !== {16'h0000, 2'b11})
      $display("FAIL mul_hi got=%h required=%h", {bus.result, bus.flag_z, bus.flag_c}, {16'h0000, 2'b11});
    else pass_cnt++;
    @(posedge clk);
    #1;
    issue(OP_MUL, 16'h00FF, 16'h0003, w);
    wait_valid(lat, irs);
    total_cnt++;
    if ({bus.result, bus.flag_c} !== {16'h02FD, 1'b0})
      $display("FAIL mul_lo got=%h required=%h", {bus.result, bus.flag_c}, {16'h02FD, 1'b0});
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int   w, lat;
    logic irs, bad;
    bus.out_ready = 1'b0;
    issue(OP_AND, 16'hF0F0, 16'hFF00, w);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!(bus.out_valid === 1'b1 && bus.in_ready === 1'b0 &&
            {bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} === {16'hF000, 4'b0100}))
        bad = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = (i == 1);
      bus.op = OP_ADD;
      bus.a = 16'h0001;
      bus.b = 16'h0001;
    end
    total_cnt++;
    if (bad) $display("FAIL stall_hold got=changed required=F000_held");
    else pass_cnt++;
    bus.out_ready = 1'b1;
    issue(OP_XOR, 16'h1234, 16'hFFFF, w);
    total_cnt++;
    if (w != 0) $display("FAIL bp_same_edge_accept got=%0d required=0", w);
    else pass_cnt++;
    wait_valid(lat, irs);
    total_cnt++;
    if (lat != 1) $display("FAIL bp_next_latency got=%0d required=1", lat);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  s_op [8] = '{OP_XOR, OP_OR, OP_SHL, OP_XOR, OP_SHR, OP_OR, OP_SHL, OP_OR};
    logic [15:0] s_a  [8] = '{16'h1234, 16'h0F00, 16'h8001, 16'hFFFF, 16'h8001, 16'h0000, 16'h00F0, 16'hA5A5};
    logic [15:0] s_b  [8] = '{16'h00FF, 16'h00F0, 16'h0001, 16'hFFFF, 16'h0001, 16'h8000, 16'h0004, 16'h0001};
    int w, wsum, base;
    bus.out_ready = 1'b1;
    wsum = 0;
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      issue(s_op[i], s_a[i], s_b[i], w);
      wsum += w;
    end
    total_cnt++;
    if (wsum != 0) $display("FAIL stream_stalls got=%0d required=0", wsum);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (n_out - base != 8) $display("FAIL stream_count got=%0d required=8", n_out - base);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_mul();
    int   w, lat;
    logic irs;
    bus.out_ready = 1'b1;
    issue(OP_MUL, 16'h1234, 16'h5678, w);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    total_cnt++;
    if ({bus.out_valid, bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== 21'h0)
      $display("FAIL async_reset got=%h required=0",
               {bus.out_valid, bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b required=1", bus.in_ready);
    else pass_cnt++;
    issue(OP_ADD, 16'h0002, 16'h0003, w);
    wait_valid(lat, irs);
    total_cnt++;
    if (bus.result !== 16'h0005) $display("FAIL post_reset_add got=%h required=0005", bus.result);
    else pass_cnt++;
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      run_monitor();
    join_none
    test_reset();
    test_add_sub();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d required=0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
